// File: rtl/alu_rs_pkg.sv
// Shared widths, opcodes, entry/operand types and the operand wakeup helper for the ALU reservation station.
package alu_rs_pkg;
  localparam int DATA_WID = 32;
  localparam int ADDR_WID = 32;
  localparam int ROB_WID  = 4;
  localparam int AGE_W    = 4;
  localparam int RS_SIZE_DEF  = 16;
  localparam int RS_IDX_W_DEF = 4;

  localparam logic [6:0] OPCODE_CAL   = 7'b0110011;
  localparam logic [6:0] OPCODE_CALI  = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [6:0] OPCODE_B     = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR  = 7'b1100111;

  typedef struct packed {
    logic                rdy;
    logic [DATA_WID-1:0] val;
  } operand_t;

  typedef struct packed {
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                funct7;
    logic                rdy1;
    logic                rdy2;
    logic [DATA_WID-1:0] val1;
    logic [DATA_WID-1:0] val2;
    logic [ROB_WID-1:0]  q1;
    logic [ROB_WID-1:0]  q2;
    logic [DATA_WID-1:0] imm;
    logic [ADDR_WID-1:0] pc;
    logic [ROB_WID-1:0]  rob_pos;
  } rs_entry_t;

  // A pending operand picks up a matching broadcast; the ALU result wins if both match.
  function automatic operand_t wake_operand(
    input operand_t            cur,
    input logic [ROB_WID-1:0]  q,
    input logic                a_en,
    input logic [ROB_WID-1:0]  a_pos,
    input logic [DATA_WID-1:0] a_val,
    input logic                l_en,
    input logic [ROB_WID-1:0]  l_pos,
    input logic [DATA_WID-1:0] l_val
  );
    operand_t r;
    r = cur;
    if (!cur.rdy) begin
      if (a_en && a_pos == q) begin
        r.rdy = 1'b1;
        r.val = a_val;
      end else if (l_en && l_pos == q) begin
        r.rdy = 1'b1;
        r.val = l_val;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/alu_rs_select.sv
// Combinational priority picker: lowest set index, or highest age with lowest-index tie-break when USE_AGE.
module alu_rs_select
  import alu_rs_pkg::*;
#(
  parameter int N       = 16,
  parameter int IDX_W   = 4,
  parameter bit USE_AGE = 1'b0
) (
  input  logic [N-1:0]       req_i,
  input  logic [N*AGE_W-1:0] age_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [AGE_W-1:0] best;
    found = 1'b0;
    idx   = '0;
    best  = '0;
    // Strict '>' keeps the earlier (lower) index on equal ages.
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && (!found || (USE_AGE && age_i[i*AGE_W +: AGE_W] > best))) begin
        found = 1'b1;
        idx   = IDX_W'(i);
        best  = age_i[i*AGE_W +: AGE_W];
      end
    end
    found_o = found;
    idx_o   = idx;
  end
endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch, broadcast wakeup, one issue per cycle.
// Define ALU_RS_OLDEST_FIRST_EN to select the oldest ready entry instead of the lowest index.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE  = RS_SIZE_DEF,
  parameter int RS_IDX_W = RS_IDX_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                dsp_en,
  input  logic [6:0]          dsp_opcode,
  input  logic [2:0]          dsp_funct3,
  input  logic                dsp_funct7,
  input  logic                dsp_rdy1,
  input  logic                dsp_rdy2,
  input  logic [DATA_WID-1:0] dsp_val1,
  input  logic [DATA_WID-1:0] dsp_val2,
  input  logic [ROB_WID-1:0]  dsp_q1,
  input  logic [ROB_WID-1:0]  dsp_q2,
  input  logic [DATA_WID-1:0] dsp_imm,
  input  logic [ADDR_WID-1:0] dsp_pc,
  input  logic [ROB_WID-1:0]  dsp_rob_pos,
  input  logic                alu_res_en,
  input  logic [ROB_WID-1:0]  alu_res_rob_pos,
  input  logic [DATA_WID-1:0] alu_res_val,
  input  logic                lsb_res_en,
  input  logic [ROB_WID-1:0]  lsb_res_rob_pos,
  input  logic [DATA_WID-1:0] lsb_res_val,
  output logic                rs_full,
  output logic                iss_en,
  output logic [6:0]          iss_opcode,
  output logic [2:0]          iss_funct3,
  output logic                iss_funct7,
  output logic [DATA_WID-1:0] iss_val1,
  output logic [DATA_WID-1:0] iss_val2,
  output logic [DATA_WID-1:0] iss_imm,
  output logic [ROB_WID-1:0]  iss_rob_pos,
  output logic [ADDR_WID-1:0] iss_pc
);
`ifdef ALU_RS_OLDEST_FIRST_EN
  localparam bit USE_AGE = 1'b1;
`else
  localparam bit USE_AGE = 1'b0;
`endif

  logic [RS_SIZE-1:0]       busy_vec;
  logic [RS_SIZE-1:0]       ready_vec;
  logic [RS_SIZE*AGE_W-1:0] age_vec;
  rs_entry_t                ent_arr [RS_SIZE];
  rs_entry_t                dsp_ent;
  operand_t                 dsp_op1, dsp_op2;
  logic                     free_found, iss_found, dsp_write;
  logic [RS_IDX_W-1:0]      free_idx, iss_idx;

  assign rs_full   = &busy_vec;
  assign dsp_write = dsp_en & ~rs_full;

  // Operands whose producer broadcasts in the dispatch cycle are captured on write.
  assign dsp_op1 = wake_operand(operand_t'({dsp_rdy1, dsp_val1}), dsp_q1,
                                alu_res_en, alu_res_rob_pos, alu_res_val,
                                lsb_res_en, lsb_res_rob_pos, lsb_res_val);
  assign dsp_op2 = wake_operand(operand_t'({dsp_rdy2, dsp_val2}), dsp_q2,
                                alu_res_en, alu_res_rob_pos, alu_res_val,
                                lsb_res_en, lsb_res_rob_pos, lsb_res_val);

  always_comb begin
    dsp_ent         = '0;
    dsp_ent.opcode  = dsp_opcode;
    dsp_ent.funct3  = dsp_funct3;
    dsp_ent.funct7  = dsp_funct7;
    dsp_ent.rdy1    = dsp_op1.rdy;
    dsp_ent.val1    = dsp_op1.val;
    dsp_ent.rdy2    = dsp_op2.rdy;
    dsp_ent.val2    = dsp_op2.val;
    dsp_ent.q1      = dsp_q1;
    dsp_ent.q2      = dsp_q2;
    dsp_ent.imm     = dsp_imm;
    dsp_ent.pc      = dsp_pc;
    dsp_ent.rob_pos = dsp_rob_pos;
  end

  for (genvar gi = 0; gi < RS_SIZE; gi++) begin : gen_ent
    rs_entry_t ent_q;
    logic      busy_q;
    operand_t  op1_w, op2_w;
    logic      dsp_hit, iss_hit;

    assign dsp_hit = dsp_write && (free_idx == RS_IDX_W'(gi));
    assign iss_hit = iss_found && (iss_idx == RS_IDX_W'(gi));
    assign op1_w = wake_operand(operand_t'({ent_q.rdy1, ent_q.val1}), ent_q.q1,
                                alu_res_en, alu_res_rob_pos, alu_res_val,
                                lsb_res_en, lsb_res_rob_pos, lsb_res_val);
    assign op2_w = wake_operand(operand_t'({ent_q.rdy2, ent_q.val2}), ent_q.q2,
                                alu_res_en, alu_res_rob_pos, alu_res_val,
                                lsb_res_en, lsb_res_rob_pos, lsb_res_val);

    always_ff @(posedge clk) begin
      if (rst) begin
        busy_q <= 1'b0;
        ent_q  <= '0;
      end else if (rdy) begin
        if (rollback) begin
          busy_q <= 1'b0;
        end else if (dsp_hit) begin
          busy_q <= 1'b1;
          ent_q  <= dsp_ent;
        end else begin
          if (iss_hit) busy_q <= 1'b0;
          if (busy_q) begin
            ent_q.rdy1 <= op1_w.rdy;
            ent_q.val1 <= op1_w.val;
            ent_q.rdy2 <= op2_w.rdy;
            ent_q.val2 <= op2_w.val;
          end
        end
      end
    end

`ifdef ALU_RS_OLDEST_FIRST_EN
    logic [AGE_W-1:0] age_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        age_q <= '0;
      end else if (rdy) begin
        if (rollback || dsp_hit) age_q <= '0;
        else if (busy_q && age_q != {AGE_W{1'b1}}) age_q <= age_q + 1'b1;
      end
    end
    assign age_vec[gi*AGE_W +: AGE_W] = age_q;
`else
    assign age_vec[gi*AGE_W +: AGE_W] = '0;
`endif

    assign busy_vec[gi]  = busy_q;
    assign ready_vec[gi] = busy_q & ent_q.rdy1 & ent_q.rdy2;
    assign ent_arr[gi]   = ent_q;
  end

  alu_rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W), .USE_AGE(1'b0)) u_free_sel (
    .req_i(~busy_vec), .age_i('0), .found_o(free_found), .idx_o(free_idx)
  );

  alu_rs_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W), .USE_AGE(USE_AGE)) u_iss_sel (
    .req_i(ready_vec), .age_i(age_vec), .found_o(iss_found), .idx_o(iss_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_en      <= 1'b0;
      iss_opcode  <= '0;
      iss_funct3  <= '0;
      iss_funct7  <= 1'b0;
      iss_val1    <= '0;
      iss_val2    <= '0;
      iss_imm     <= '0;
      iss_rob_pos <= '0;
      iss_pc      <= '0;
    end else if (rdy) begin
      if (rollback) begin
        iss_en <= 1'b0;
      end else begin
        iss_en <= iss_found;
        if (iss_found) begin
          iss_opcode  <= ent_arr[iss_idx].opcode;
          iss_funct3  <= ent_arr[iss_idx].funct3;
          iss_funct7  <= ent_arr[iss_idx].funct7;
          iss_val1    <= ent_arr[iss_idx].val1;
          iss_val2    <= ent_arr[iss_idx].val2;
          iss_imm     <= ent_arr[iss_idx].imm;
          iss_rob_pos <= ent_arr[iss_idx].rob_pos;
          iss_pc      <= ent_arr[iss_idx].pc;
        end
      end
    end
  end

  // free_found is implied by ~rs_full; kept visible for debug probes.
  logic unused_free_found;
  assign unused_free_found = free_found;
endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs; expected values are hand-computed per step.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic                clk = 1'b0;
  logic                rst, rdy, rollback, dsp_en;
  logic [6:0]          dsp_opcode;
  logic [2:0]          dsp_funct3;
  logic                dsp_funct7, dsp_rdy1, dsp_rdy2;
  logic [DATA_WID-1:0] dsp_val1, dsp_val2, dsp_imm;
  logic [ROB_WID-1:0]  dsp_q1, dsp_q2, dsp_rob_pos;
  logic [ADDR_WID-1:0] dsp_pc;
  logic                alu_res_en, lsb_res_en;
  logic [ROB_WID-1:0]  alu_res_rob_pos, lsb_res_rob_pos;
  logic [DATA_WID-1:0] alu_res_val, lsb_res_val;
  logic                rs_full, iss_en, iss_funct7;
  logic [6:0]          iss_opcode;
  logic [2:0]          iss_funct3;
  logic [DATA_WID-1:0] iss_val1, iss_val2, iss_imm;
  logic [ROB_WID-1:0]  iss_rob_pos;
  logic [ADDR_WID-1:0] iss_pc;

  int n_cmp = 0;
  int n_bad = 0;

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .dsp_en(dsp_en), .dsp_opcode(dsp_opcode), .dsp_funct3(dsp_funct3), .dsp_funct7(dsp_funct7),
    .dsp_rdy1(dsp_rdy1), .dsp_rdy2(dsp_rdy2), .dsp_val1(dsp_val1), .dsp_val2(dsp_val2),
    .dsp_q1(dsp_q1), .dsp_q2(dsp_q2), .dsp_imm(dsp_imm), .dsp_pc(dsp_pc), .dsp_rob_pos(dsp_rob_pos),
    .alu_res_en(alu_res_en), .alu_res_rob_pos(alu_res_rob_pos), .alu_res_val(alu_res_val),
    .lsb_res_en(lsb_res_en), .lsb_res_rob_pos(lsb_res_rob_pos), .lsb_res_val(lsb_res_val),
    .rs_full(rs_full), .iss_en(iss_en), .iss_opcode(iss_opcode), .iss_funct3(iss_funct3),
    .iss_funct7(iss_funct7), .iss_val1(iss_val1), .iss_val2(iss_val2), .iss_imm(iss_imm),
    .iss_rob_pos(iss_rob_pos), .iss_pc(iss_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic dsp(input logic [6:0] op, input logic f7, input bit r1, input int v1, input int q1,
                     input bit r2, input int v2, input int q2, input int rob);
    dsp_en      = 1'b1;
    dsp_opcode  = op;
    dsp_funct3  = 3'd0;
    dsp_funct7  = f7;
    dsp_rdy1    = r1;
    dsp_val1    = DATA_WID'(v1);
    dsp_q1      = ROB_WID'(q1);
    dsp_rdy2    = r2;
    dsp_val2    = DATA_WID'(v2);
    dsp_q2      = ROB_WID'(q2);
    dsp_rob_pos = ROB_WID'(rob);
  endtask

  task automatic alu_bc(input int tag, input int val);
    alu_res_en = 1'b1; alu_res_rob_pos = ROB_WID'(tag); alu_res_val = DATA_WID'(val);
  endtask

  task automatic lsb_bc(input int tag, input int val);
    lsb_res_en = 1'b1; lsb_res_rob_pos = ROB_WID'(tag); lsb_res_val = DATA_WID'(val);
  endtask

  task automatic quiet();
    dsp_en = 1'b0; alu_res_en = 1'b0; lsb_res_en = 1'b0; rollback = 1'b0;
  endtask

  initial begin
    logic [ROB_WID-1:0] first_rob, second_rob;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; dsp_en = 1'b0;
    dsp_opcode = '0; dsp_funct3 = '0; dsp_funct7 = 1'b0; dsp_rdy1 = 1'b0; dsp_rdy2 = 1'b0;
    dsp_val1 = '0; dsp_val2 = '0; dsp_q1 = '0; dsp_q2 = '0; dsp_imm = '0; dsp_pc = '0; dsp_rob_pos = '0;
    alu_res_en = 1'b0; alu_res_rob_pos = '0; alu_res_val = '0;
    lsb_res_en = 1'b0; lsb_res_rob_pos = '0; lsb_res_val = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_iss_en", 64'(iss_en), 64'd0);
    chk("rst_val1", 64'(iss_val1), 64'd0);
    chk("rst_rob", 64'(iss_rob_pos), 64'd0);
    chk("rst_opcode", 64'(iss_opcode), 64'd0);
    chk("rst_full", 64'(rs_full), 64'd0);

    // ADD 5,7 both ready: issue two edges after dispatch
    dsp(OPCODE_CAL, 1'b0, 1, 5, 0, 1, 7, 0, 2);
    tick(); quiet();
    chk("add_early", 64'(iss_en), 64'd0);
    tick();
    chk("add_en", 64'(iss_en), 64'd1);
    chk("add_val1", 64'(iss_val1), 64'd5);
    chk("add_val2", 64'(iss_val2), 64'd7);
    chk("add_rob", 64'(iss_rob_pos), 64'd2);
    chk("add_op", 64'(iss_opcode), 64'(OPCODE_CAL));
    tick();
    chk("pulse_end", 64'(iss_en), 64'd0);
    chk("hold_val1", 64'(iss_val1), 64'd5);

    // SUB with q1=3 woken by ALU broadcast of 0x10
    dsp(OPCODE_CAL, 1'b1, 0, 0, 3, 1, 2, 0, 4);
    tick(); quiet();
    tick();
    alu_bc(3, 'h10);
    tick(); quiet();
    chk("sub_wait", 64'(iss_en), 64'd0);
    tick();
    chk("sub_en", 64'(iss_en), 64'd1);
    chk("sub_val1", 64'(iss_val1), 64'h10);
    chk("sub_f7", 64'(iss_funct7), 64'd1);
    chk("sub_rob", 64'(iss_rob_pos), 64'd4);

    // q2=6 captured from same-cycle LSB broadcast
    dsp(OPCODE_CAL, 1'b0, 1, 1, 0, 0, 0, 6, 5);
    lsb_bc(6, 'hABCD);
    tick(); quiet();
    chk("cap_early", 64'(iss_en), 64'd0);
    tick();
    chk("cap_en", 64'(iss_en), 64'd1);
    chk("cap_val2", 64'(iss_val2), 64'hABCD);
    chk("cap_rob", 64'(iss_rob_pos), 64'd5);

    // rdy low freezes the pending issue for one edge
    dsp(OPCODE_JAL, 1'b0, 1, 0, 0, 1, 0, 0, 7);
    dsp_imm = 32'h123; dsp_pc = 32'h400;
    tick(); quiet();
    rdy = 1'b0;
    tick();
    chk("frz_en", 64'(iss_en), 64'd0);
    rdy = 1'b1;
    tick();
    chk("frz_rel", 64'(iss_en), 64'd1);
    chk("frz_imm", 64'(iss_imm), 64'h123);
    chk("frz_pc", 64'(iss_pc), 64'h400);
    tick();

    // fill all 16 slots with pending operands, slot i waits on tag i
    for (int i = 0; i < 16; i++) begin
      dsp(OPCODE_CALI, 1'b0, 0, 0, i, 1, 0, 0, i);
      tick();
    end
    quiet();
    chk("full", 64'(rs_full), 64'd1);
    dsp(OPCODE_CAL, 1'b0, 1, 9, 0, 1, 9, 0, 9);
    tick(); quiet();
    chk("ovf_a", 64'(iss_en), 64'd0);
    tick();
    chk("ovf_b", 64'(iss_en), 64'd0);
    chk("still_full", 64'(rs_full), 64'd1);
    alu_bc(7, 'h77);
    tick(); quiet();
    chk("wk_full", 64'(rs_full), 64'd1);
    chk("wk_en", 64'(iss_en), 64'd0);
    tick();
    chk("free_en", 64'(iss_en), 64'd1);
    chk("free_rob", 64'(iss_rob_pos), 64'd7);
    chk("free_val1", 64'(iss_val1), 64'h77);
    chk("free_full", 64'(rs_full), 64'd0);

    // rollback with simultaneous dispatch: nothing survives
    rollback = 1'b1;
    tick(); quiet();
    for (int i = 1; i <= 4; i++) begin
      dsp(OPCODE_CAL, 1'b0, 0, 0, i, 1, 0, 0, 9 + i);
      tick();
    end
    dsp(OPCODE_CAL, 1'b0, 1, 1, 0, 1, 1, 0, 14);
    rollback = 1'b1;
    tick(); quiet();
    chk("rb_en", 64'(iss_en), 64'd0);
    chk("rb_full", 64'(rs_full), 64'd0);
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) alu_bc(i, 100 + i);
      tick(); quiet();
      chk("rb_noiss", 64'(iss_en), 64'd0);
    end

    // slot 5 older than slot 1; both woken by one broadcast
    dsp(OPCODE_CAL, 1'b0, 0, 0, 12, 1, 0, 0, 0); tick();
    dsp(OPCODE_CAL, 1'b0, 0, 0, 13, 1, 0, 0, 1); tick();
    dsp(OPCODE_CAL, 1'b0, 0, 0, 14, 1, 0, 0, 2); tick();
    dsp(OPCODE_CAL, 1'b0, 0, 0, 15, 1, 0, 0, 3); tick();
    dsp(OPCODE_CAL, 1'b0, 0, 0, 11, 1, 0, 0, 4); tick();
    dsp(OPCODE_CAL, 1'b0, 0, 0, 8, 1, 0, 0, 5); tick();
    quiet();
    alu_bc(13, 'h13);
    tick(); quiet();
    tick();
    chk("s1_en", 64'(iss_en), 64'd1);
    chk("s1_rob", 64'(iss_rob_pos), 64'd1);
    dsp(OPCODE_CAL, 1'b0, 0, 0, 8, 1, 0, 0, 9);
    tick(); quiet();
    lsb_bc(8, 'h88);
    tick(); quiet();
`ifdef ALU_RS_OLDEST_FIRST_EN
    first_rob = 4'd5; second_rob = 4'd9;
`else
    first_rob = 4'd9; second_rob = 4'd5;
`endif
    tick();
    chk("ord1_en", 64'(iss_en), 64'd1);
    chk("ord1_rob", 64'(iss_rob_pos), 64'(first_rob));
    tick();
    chk("ord2_en", 64'(iss_en), 64'd1);
    chk("ord2_rob", 64'(iss_rob_pos), 64'(second_rob));
    chk("ord2_val1", 64'(iss_val1), 64'h88);
    tick();
    chk("ord_done", 64'(iss_en), 64'd0);

    rollback = 1'b1;
    tick(); quiet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
